jk_counter_reg: RTL and testbench



---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 28 ++
 rtl/jk_counter_reg.sv | 102 ++++++++++
 tb/tb_jk_counter_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and constants for the JK counter register bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK   = 2'b00,
    JK_MODE_UP   = 2'b01,
    JK_MODE_DOWN = 2'b10,
    JK_MODE_LOAD = 2'b11
  } jk_mode_e;

  // {J,K} pair encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to a per-cell value
// and an update enable.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit bank of JK cells acting as JK register, up/down counter or loadable
// register. Define JK_SATURATE_EN to make UP/DOWN saturate instead of wrapping.
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  jk_mode_e         mode_e;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic             sat_hold;

  assign mode_e = jk_mode_e'(mode);

  // Ripple toggle conditions: bit i toggles when all lower bits are 1 (up) / 0 (down).
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c   = 1'b1;
    dn_c   = 1'b1;
    up_tgl = '0;
    dn_tgl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_tgl[i] = up_c;
      dn_tgl[i] = dn_c;
      up_c      = up_c & Q[i];
      dn_c      = dn_c & ~Q[i];
    end
  end

  assign tc = ((mode_e == JK_MODE_UP)   && (&Q)) ||
              ((mode_e == JK_MODE_DOWN) && (~|Q));

`ifdef JK_SATURATE_EN
  assign sat_hold = tc;
`else
  assign sat_hold = 1'b0;
`endif

  always_comb begin
    j_eff = J;
    k_eff = K;
    case (mode_e)
      JK_MODE_JK: begin
        j_eff = J;
        k_eff = K;
      end
      JK_MODE_UP: begin
        j_eff = sat_hold ? '0 : up_tgl;
        k_eff = sat_hold ? '0 : up_tgl;
      end
      JK_MODE_DOWN: begin
        j_eff = sat_hold ? '0 : dn_tgl;
        k_eff = sat_hold ? '0 : dn_tgl;
      end
      JK_MODE_LOAD: begin
        j_eff = d;
        k_eff = ~d;
      end
      default: begin
        j_eff = J;
        k_eff = K;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .en      (en),
      .j       (j_eff[i]),
      .k       (k_eff[i]),
      .q       (Q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en && tc;
    end
  end

endmodule

// File: tb/tb_jk_counter_reg.sv
// Directed self-checking bench for jk_counter_reg (WIDTH=8, RST_VAL=8'h5A);
// expectations follow JK_SATURATE_EN when it is defined.
module tb_jk_counter_reg;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RSTV  = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] J;
  logic [7:0] K;
  logic [7:0] d;
  logic [7:0] Q;
  logic       tc;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  jk_counter_reg #(.WIDTH(WIDTH), .RST_VAL(RSTV)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .J    (J),
    .K    (K),
    .d    (d),
    .Q    (Q),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 2'b11; d = v;
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rst = 1'b1; en = 1'($urandom); mode = 2'($urandom);
      J = 8'hFF; K = 8'hFF; d = 8'($urandom);
      tick();
      checks++; if (Q !== RSTV) begin errors++; $display("FAIL reset_q cyc%0d: got %h exp %h", c, Q, RSTV); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc%0d: got %b exp 0", c, wrap); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc cyc%0d: got %b exp 0", c, tc); end
    end
    rst = 1'b0;
  endtask

  task automatic test_jk();
    load(8'h0F);
    checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL jk_load: got %h exp 0f", Q); end
    // per bit 7..0: tgl,set,clr,hold,hold,set,clr,tgl applied to 0000_1111
    mode = 2'b00; J = 8'b1100_0101; K = 8'b1010_0011; d = 8'h33;
    tick();
    checks++; if (Q !== 8'hCC) begin errors++; $display("FAIL jk_update: got %h exp cc", Q); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL jk_tc: got %b exp 0", tc); end
    en = 1'b0; mode = 2'b11; d = 8'h00;
    tick();
    checks++; if (Q !== 8'hCC) begin errors++; $display("FAIL en_low_load: got %h exp cc", Q); end
  endtask

  task automatic test_up();
    logic [7:0] exp_q2;
    load(8'hFE);
    mode = 2'b01; J = 8'h00; K = 8'h00;
    tick();
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL up1_q: got %h exp ff", Q); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up1_tc: got %b exp 1", tc); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up1_wrap: got %b exp 0", wrap); end
    tick();
`ifdef JK_SATURATE_EN
    exp_q2 = 8'hFF;
`else
    exp_q2 = 8'h00;
`endif
    checks++; if (Q !== exp_q2) begin errors++; $display("FAIL up2_q: got %h exp %h", Q, exp_q2); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL up2_wrap: got %b exp 1", wrap); end
    en = 1'b0;
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up3_wrap: got %b exp 0", wrap); end
    checks++; if (Q !== exp_q2) begin errors++; $display("FAIL up3_hold: got %h exp %h", Q, exp_q2); end
  endtask

  task automatic test_down();
    logic [7:0] exp_q2;
    logic       exp_tc;
    load(8'h01);
    mode = 2'b10;
    tick();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL dn1_q: got %h exp 00", Q); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn1_tc: got %b exp 1", tc); end
    tick();
`ifdef JK_SATURATE_EN
    exp_q2 = 8'h00; exp_tc = 1'b1;
`else
    exp_q2 = 8'hFF; exp_tc = 1'b0;
`endif
    checks++; if (Q !== exp_q2) begin errors++; $display("FAIL dn2_q: got %h exp %h", Q, exp_q2); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dn2_wrap: got %b exp 1", wrap); end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (Q !== exp_q2) begin errors++; $display("FAIL dn_hold_q cyc%0d: got %h exp %h", c, Q, exp_q2); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL dn_hold_wrap cyc%0d: got %b exp 0", c, wrap); end
      checks++; if (tc !== exp_tc) begin errors++; $display("FAIL dn_hold_tc cyc%0d: got %b exp %b", c, tc, exp_tc); end
    end
  endtask

  task automatic test_reset_mid();
    load(8'h10);
    mode = 2'b01;
    tick();
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL mid1_q: got %h exp 11", Q); end
    tick();
    checks++; if (Q !== 8'h12) begin errors++; $display("FAIL mid2_q: got %h exp 12", Q); end
    rst = 1'b1;
    tick();
    checks++; if (Q !== RSTV) begin errors++; $display("FAIL mid_rst_q: got %h exp %h", Q, RSTV); end
    rst = 1'b0;
    tick();
    checks++; if (Q !== 8'h5B) begin errors++; $display("FAIL mid_resume_q: got %h exp 5b", Q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL mid_resume_wrap: got %b exp 0", wrap); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [3];
    logic [1:0] seq_m [3];
    exp_q[0] = 8'h80; exp_q[1] = 8'h7F; exp_q[2] = 8'h80;
    seq_m[0] = 2'b11; seq_m[1] = 2'b10; seq_m[2] = 2'b01;
    en = 1'b1; d = 8'h80;
    for (int c = 0; c < 3; c++) begin
      mode = seq_m[c];
      tick();
      checks++; if (Q !== exp_q[c]) begin errors++; $display("FAIL b2b_q step%0d: got %h exp %h", c, Q, exp_q[c]); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL b2b_tc step%0d: got %b exp 0", c, tc); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; J = '0; K = '0; d = '0;
    test_reset();
    test_jk();
    test_up();
    test_down();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
